// File: rtl/clock_divider_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_prog_pkg
// Brief    : Shared constants, channel mode encoding and width helper.
// Revision : 1.0
// ============================================================================
package clock_divider_prog_pkg;

  localparam int c_CNT_W       = 16;
  localparam int c_DEFAULT_DIV = 49;

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'd0,
    MODE_IDLE  = 2'd1,
    MODE_TERM  = 2'd2,
    MODE_COUNT = 2'd3
  } ch_mode_e;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_prog_ch.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_prog_ch
// Brief    : One divider channel with shadowed divisor applied at terminal count.
// Revision : 1.0
// ============================================================================
module clock_divider_prog_ch
  import clock_divider_prog_pkg::*;
#(
  parameter int              CNT_W       = c_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(c_DEFAULT_DIV)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_pending
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active_div;
  logic [CNT_W-1:0] r_shadow_div;
  logic             r_clk;
  logic             r_tick;
  logic             r_pending;
  ch_mode_e         w_mode;
  logic [CNT_W-1:0] w_next_div;

  always_comb begin
    w_mode = MODE_COUNT;
    if (i_sync_clr)                 w_mode = MODE_CLEAR;
    else if (!i_en)                 w_mode = MODE_IDLE;
    else if (r_cnt == r_active_div) w_mode = MODE_TERM;
  end

  // A write landing on an apply cycle bypasses the shadow.
  assign w_next_div = i_wr ? i_wr_div : r_shadow_div;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= '0;
      r_active_div <= DEFAULT_DIV;
      r_shadow_div <= DEFAULT_DIV;
      r_clk        <= 1'b0;
      r_tick       <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      if (i_wr) r_shadow_div <= i_wr_div;
      case (w_mode)
        MODE_CLEAR, MODE_IDLE: begin
          r_cnt        <= '0;
          r_clk        <= 1'b0;
          r_tick       <= 1'b0;
          r_active_div <= w_next_div;
          r_pending    <= 1'b0;
        end
        MODE_TERM: begin
          r_cnt        <= '0;
          r_clk        <= ~r_clk;
          r_tick       <= 1'b1;
          r_active_div <= w_next_div;
          r_pending    <= 1'b0;
        end
        default: begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
          if (i_wr) r_pending <= 1'b1;
        end
      endcase
    end
  end

  assign o_clk     = r_clk;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_prog
// Brief    : N-channel programmable clock divider with shared divisor write port.
// Revision : 1.0
// ============================================================================
module clock_divider_prog
  import clock_divider_prog_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = c_CNT_W,
  parameter int DEFAULT_DIV = c_DEFAULT_DIV,
  localparam int CH_W       = ch_width(N_CH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_CH-1:0]  i_en,
  input  logic             i_sync_clr,
  input  logic             i_wr_en,
  input  logic [CH_W-1:0]  i_wr_ch,
  input  logic [CNT_W-1:0] i_wr_div,
  output logic [N_CH-1:0]  o_clk,
  output logic [N_CH-1:0]  o_tick,
  output logic [N_CH-1:0]  o_pending
);

  logic [N_CH-1:0] w_wr_sel;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Addresses at or above N_CH match no channel and are dropped.
    localparam logic [CH_W-1:0] c_CH_IDX = CH_W'(g);

    assign w_wr_sel[g] = i_wr_en && (i_wr_ch == c_CH_IDX);

    clock_divider_prog_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
    ) u_ch (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_en       (i_en[g]),
      .i_sync_clr (i_sync_clr),
      .i_wr       (w_wr_sel[g]),
      .i_wr_div   (i_wr_div),
      .o_clk      (o_clk[g]),
      .o_tick     (o_tick[g]),
      .o_pending  (o_pending[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_prog
// Brief    : Directed self-checking bench for clock_divider_prog.
// Revision : 1.0
// ============================================================================
module tb_clock_divider_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        sync_clr;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_div;
  logic [3:0]  o_clk, o_tick, o_pending;

  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [2:0]  o_clk3, o_tick3, o_pending3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_divider_prog #(.N_CH(4), .CNT_W(16), .DEFAULT_DIV(49)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_sync_clr(sync_clr),
    .i_wr_en(wr_en), .i_wr_ch(wr_ch), .i_wr_div(wr_div),
    .o_clk(o_clk), .o_tick(o_tick), .o_pending(o_pending)
  );

  clock_divider_prog #(.N_CH(3), .CNT_W(16), .DEFAULT_DIV(49)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_en(en[2:0]), .i_sync_clr(sync_clr),
    .i_wr_en(wr_en3), .i_wr_ch(wr_ch3), .i_wr_div(wr_div),
    .o_clk(o_clk3), .o_tick(o_tick3), .o_pending(o_pending3)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 4'h0; sync_clr = 1'b0;
    wr_en = 1'b0; wr_ch = 2'd0; wr_div = 16'd0;
    wr_en3 = 1'b0; wr_ch3 = 2'd0;
    #1;
    chk("reset_clk",     {12'd0, o_clk},     16'h0);
    chk("reset_tick",    {12'd0, o_tick},    16'h0);
    chk("reset_pending", {12'd0, o_pending}, 16'h0);
    step(2);
    rst = 1'b0; en = 4'hF;

    // Defaults: tick every 50 cycles, clock period 100
    step(49); chk("def_tick_e49",  {12'd0, o_tick}, 16'h0);
    step(1);  chk("def_tick_e50",  {12'd0, o_tick}, 16'hF);
              chk("def_clk_e50",   {12'd0, o_clk},  16'hF);
    step(1);  chk("def_tick_e51",  {12'd0, o_tick}, 16'h0);
    step(49); chk("def_tick_e100", {12'd0, o_tick}, 16'hF);
              chk("def_clk_e100",  {12'd0, o_clk},  16'h0);
              chk("def_pending",   {12'd0, o_pending}, 16'h0);

    // Channel 1: D=3 written at cnt=10
    step(10);
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd3;
    step(1);
    wr_en = 1'b0;
    chk("ch1_pending_set",  {12'd0, o_pending}, 16'h2);
    step(38); chk("ch1_pending_hold", {12'd0, o_pending}, 16'h2);
              chk("ch1_no_early_tick", {12'd0, o_tick}, 16'h0);
    step(1);  chk("ch1_apply_tick",   {12'd0, o_tick},    16'hF);
              chk("ch1_apply_pend",   {12'd0, o_pending}, 16'h0);
              chk("ch1_apply_clk",    {12'd0, o_clk},     16'hF);
    step(3);  chk("ch1_e153_tick",    {12'd0, o_tick},    16'h0);
    step(1);  chk("ch1_e154_tick",    {12'd0, o_tick},    16'h2);
              chk("ch1_e154_clk",     {12'd0, o_clk},     16'hD);
    step(4);  chk("ch1_e158_tick",    {12'd0, o_tick},    16'h2);
              chk("ch1_e158_clk",     {12'd0, o_clk},     16'hF);

    // Channel 2: D=0, then D=5 written on a terminal cycle
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd0;
    step(1);
    wr_en = 1'b0;
    chk("ch2_pending_set", {12'd0, o_pending}, 16'h4);
    step(41); chk("ch2_apply_pend", {12'd0, o_pending}, 16'h0);
              chk("ch2_apply_tick", {15'd0, o_tick[2]}, 16'h1);
    step(1);  chk("ch2_d0_tick_a",  {15'd0, o_tick[2]}, 16'h1);
              chk("ch2_d0_clk_a",   {15'd0, o_clk[2]},  16'h1);
    step(1);  chk("ch2_d0_tick_b",  {15'd0, o_tick[2]}, 16'h1);
              chk("ch2_d0_clk_b",   {15'd0, o_clk[2]},  16'h0);
    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd5;
    step(1);
    wr_en = 1'b0;
    chk("ch2_term_wr_pend", {15'd0, o_pending[2]}, 16'h0);
    chk("ch2_term_wr_tick", {15'd0, o_tick[2]},    16'h1);
    step(5);  chk("ch2_d5_no_tick", {15'd0, o_tick[2]}, 16'h0);
    step(1);  chk("ch2_d5_tick",    {15'd0, o_tick[2]}, 16'h1);
              chk("ch2_d5_clk",     {15'd0, o_clk[2]},  16'h0);

    // Channel 0: idle for 3 cycles at cnt=20 while high
    step(61); chk("ch0_high_pre_idle", {15'd0, o_clk[0]}, 16'h1);
    en = 4'hE;
    step(1);  chk("ch0_idle_clk",  {15'd0, o_clk[0]},  16'h0);
              chk("ch0_idle_tick", {15'd0, o_tick[0]}, 16'h0);
    step(2);
    en = 4'hF;
    step(49); chk("ch0_reen_no_tick", {15'd0, o_tick[0]}, 16'h0);
    step(1);  chk("ch0_reen_tick",    {15'd0, o_tick[0]}, 16'h1);
              chk("ch0_reen_clk",     {15'd0, o_clk[0]},  16'h1);

    // Sync clear aligns channels; invalid address on 3-channel instance
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    chk("sclr_clk",  {12'd0, o_clk},  16'h0);
    chk("sclr_tick", {12'd0, o_tick}, 16'h0);
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_div = 16'd2;
    step(1);
    wr_en3 = 1'b0;
    chk("bad_addr_pending", {13'd0, o_pending3}, 16'h0);
    step(3);  chk("sclr_ch1_tick", {12'd0, o_tick}, 16'h2);
    step(2);  chk("sclr_ch2_tick", {12'd0, o_tick}, 16'h4);
    step(44); chk("sclr_aligned_tick", {12'd0, o_tick}, 16'h9);
              chk("sclr_aligned_clk",  {12'd0, o_clk},  16'h9);
              chk("bad_addr_tick3",    {13'd0, o_tick3}, 16'h7);

    // Asynchronous reset mid-count
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd7;
    step(1);
    wr_en = 1'b0;
    chk("pre_rst_pending", {12'd0, o_pending}, 16'h8);
    step(4);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_clk",     {12'd0, o_clk},     16'h0);
    chk("async_rst_tick",    {12'd0, o_tick},    16'h0);
    chk("async_rst_pending", {12'd0, o_pending}, 16'h0);
    step(1);
    rst = 1'b0;
    step(49); chk("post_rst_no_tick", {12'd0, o_tick}, 16'h0);
    step(1);  chk("post_rst_tick",    {12'd0, o_tick}, 16'hF);
              chk("post_rst_clk",     {12'd0, o_clk},  16'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
